// File: rtl/fpadd_bf16xn_pipe.sv
// rtl/fpadd_bf16xn_pipe.sv - LANES-wide packed bf16 add/sub, RNE with DAZ/FTZ, STAGES-deep stallable pipe.
// Optional per-lane {invalid, overflow, underflow, inexact} flags port under FPADD_BF16XN_FLAGS_EN.
module fpadd_bf16xn_pipe #(
    parameter int LANES  = 2,
    parameter int STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES-1:0]      in_sub,
    input  logic [16*LANES-1:0]   X,
    input  logic [16*LANES-1:0]   Y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*LANES-1:0]   R
`ifdef FPADD_BF16XN_FLAGS_EN
    ,
    output logic [4*LANES-1:0]    flags
`endif
);

`ifdef FPADD_BF16XN_FLAGS_EN
    localparam int LW = 20;
`else
    localparam int LW = 16;
`endif

    function automatic logic [LW-1:0] add_lane(input logic [15:0] a, input logic [15:0] b_in,
                                               input logic sub);
        logic [15:0] b, res;
        logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap, sl, found, g, rs, up;
        logic [7:0]  el, d, ml, ms;
        logic [23:0] wide;
        logic [10:0] sig_l, sig_s, m;
        logic [11:0] s12;
        logic [3:0]  lz;
        logic [9:0]  e;
        logic [8:0]  sig9;
`ifdef FPADD_BF16XN_FLAGS_EN
        logic [3:0]  fl;
        fl = 4'b0;
`endif
        b      = {b_in[15] ^ sub, b_in[14:0]};
        a_nan  = (&a[14:7]) && (|a[6:0]);
        b_nan  = (&b[14:7]) && (|b[6:0]);
        a_inf  = (&a[14:7]) && !(|a[6:0]);
        b_inf  = (&b[14:7]) && !(|b[6:0]);
        a_zero = ~|a[14:7];
        b_zero = ~|b[14:7];
        res = 16'h0; swap = 1'b0; sl = 1'b0; found = 1'b0; g = 1'b0; rs = 1'b0; up = 1'b0;
        el = 8'h0; d = 8'h0; ml = 8'h0; ms = 8'h0; wide = 24'h0; sig_l = 11'h0; sig_s = 11'h0;
        m = 11'h0; s12 = 12'h0; lz = 4'h0; e = 10'h0; sig9 = 9'h0;
        if (a_nan || b_nan) begin
            res = 16'h7FC0;
`ifdef FPADD_BF16XN_FLAGS_EN
            fl[3] = (a_nan && !a[6]) || (b_nan && !b[6]);
`endif
        end else if (a_inf && b_inf) begin
            res = (a[15] != b[15]) ? 16'h7FC0 : a;
`ifdef FPADD_BF16XN_FLAGS_EN
            fl[3] = (a[15] != b[15]);
`endif
        end else if (a_inf) begin
            res = a;
        end else if (b_inf) begin
            res = b;
        end else if (a_zero && b_zero) begin
            res = {a[15] & b[15], 15'h0};
        end else if (a_zero) begin
            res = b;
        end else if (b_zero) begin
            res = a;
        end else begin
            swap  = b[14:0] > a[14:0];
            sl    = swap ? b[15] : a[15];
            el    = swap ? b[14:7] : a[14:7];
            ml    = {1'b1, swap ? b[6:0] : a[6:0]};
            ms    = {1'b1, swap ? a[6:0] : b[6:0]};
            d     = el - (swap ? a[14:7] : b[14:7]);
            // Small operand lands in [23:16]; G,R at [15:14], everything below folds into sticky.
            wide  = (d >= 8'd24) ? 24'h0 : ({ms, 16'h0} >> d);
            sig_s = (d >= 8'd24) ? 11'd1 : {wide[23:14], |wide[13:0]};
            sig_l = {ml, 3'b000};
            s12   = (a[15] == b[15]) ? ({1'b0, sig_l} + {1'b0, sig_s})
                                     : ({1'b0, sig_l} - {1'b0, sig_s});
            if (s12 == 12'h0) begin
                res = 16'h0000;
            end else begin
                if (s12[11]) begin
                    m = {s12[11:2], s12[1] | s12[0]};
                    e = {2'b00, el} + 10'd1;
                end else begin
                    for (int i = 10; i >= 0; i--) begin
                        if (!found) begin
                            if (s12[i]) found = 1'b1;
                            else        lz = lz + 4'd1;
                        end
                    end
                    m = s12[10:0] << lz;
                    e = {2'b00, el} - {6'b0, lz};
                end
                g    = m[2];
                rs   = m[1] | m[0];
                up   = g && (rs || m[3]);
                sig9 = {1'b0, m[10:3]} + {8'b0, up};
                if (sig9[8]) e = e + 10'd1;
                if ($signed(e) >= 10'sd255)    res = {sl, 15'h7F80};
                else if ($signed(e) <= 10'sd0) res = {sl, 15'h0000};
                else                           res = {sl, e[7:0], sig9[6:0]};
`ifdef FPADD_BF16XN_FLAGS_EN
                fl[2] = ($signed(e) >= 10'sd255);
                fl[1] = ($signed(e) <= 10'sd0);
                fl[0] = g | rs | fl[2] | fl[1];
`endif
            end
        end
`ifdef FPADD_BF16XN_FLAGS_EN
        return {fl, res};
`else
        return res;
`endif
    endfunction

    logic [16*LANES-1:0] w_res;
    logic                w_stall;
    logic [STAGES-1:0]   r_vld;
    logic [16*LANES-1:0] r_dat [STAGES];
`ifdef FPADD_BF16XN_FLAGS_EN
    logic [4*LANES-1:0]  w_flg;
    logic [4*LANES-1:0]  r_flg [STAGES];
`endif

    always_comb begin
        w_res = '0;
`ifdef FPADD_BF16XN_FLAGS_EN
        w_flg = '0;
`endif
        for (int i = 0; i < LANES; i++) begin
`ifdef FPADD_BF16XN_FLAGS_EN
            {w_flg[4*i +: 4], w_res[16*i +: 16]} = add_lane(X[16*i +: 16], Y[16*i +: 16], in_sub[i]);
`else
            w_res[16*i +: 16] = add_lane(X[16*i +: 16], Y[16*i +: 16], in_sub[i]);
`endif
        end
    end

    // One global stall freezes every stage, so bubbles and words keep their relative spacing.
    assign w_stall   = r_vld[STAGES-1] && !out_ready;
    assign in_ready  = !w_stall;
    assign out_valid = r_vld[STAGES-1];
    assign R         = r_dat[STAGES-1];
`ifdef FPADD_BF16XN_FLAGS_EN
    assign flags     = r_flg[STAGES-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int s = 0; s < STAGES; s++) begin
                r_dat[s] <= '0;
`ifdef FPADD_BF16XN_FLAGS_EN
                r_flg[s] <= '0;
`endif
            end
        end else if (!w_stall) begin
            r_vld[0] <= in_valid;
            r_dat[0] <= w_res;
`ifdef FPADD_BF16XN_FLAGS_EN
            r_flg[0] <= w_flg;
`endif
            for (int s = 1; s < STAGES; s++) begin
                r_vld[s] <= r_vld[s-1];
                r_dat[s] <= r_dat[s-1];
`ifdef FPADD_BF16XN_FLAGS_EN
                r_flg[s] <= r_flg[s-1];
`endif
            end
        end
    end

endmodule

// File: tb/tb_fpadd_bf16xn_pipe.sv
// tb/tb_fpadd_bf16xn_pipe.sv - directed + randomized bench for fpadd_bf16xn_pipe (2x2 and 4x3 instances).
module tb_fpadd_bf16xn_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [1:0]  a_in_sub;
    logic [31:0] a_x, a_y, a_r;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [3:0]  b_in_sub;
    logic [63:0] b_x, b_y, b_r;
`ifdef FPADD_BF16XN_FLAGS_EN
    logic [7:0]  a_flags;
    logic [15:0] b_flags;
`endif

    fpadd_bf16xn_pipe #(.LANES(2), .STAGES(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sub(a_in_sub),
        .X(a_x), .Y(a_y), .out_valid(a_out_valid), .out_ready(a_out_ready), .R(a_r)
`ifdef FPADD_BF16XN_FLAGS_EN
        , .flags(a_flags)
`endif
    );

    fpadd_bf16xn_pipe #(.LANES(4), .STAGES(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sub(b_in_sub),
        .X(b_x), .Y(b_y), .out_valid(b_out_valid), .out_ready(b_out_ready), .R(b_r)
`ifdef FPADD_BF16XN_FLAGS_EN
        , .flags(b_flags)
`endif
    );

    int n_err = 0;
    int n_chk = 0;
    logic [31:0] qa[$];
    logic [63:0] qb[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: exact value of each bf16 as a real, one IEEE double add, then RNE down to bf16.
    function automatic real bf_to_real(input logic [15:0] h);
        real v;
        int  e;
        v = 1.0 + real'(h[6:0]) / 128.0;
        e = int'(h[14:7]) - 127;
        for (int i = 0; i < e; i++)  v = v * 2.0;
        for (int i = 0; i < -e; i++) v = v / 2.0;
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] real_to_bf(input real r);
        logic [63:0] bits;
        logic [8:0]  m;
        logic        up;
        int          e;
        if (r == 0.0) return 16'h0000;
        bits = $realtobits(r);
        e    = int'(bits[62:52]) - 1023 + 127;
        up   = bits[44] && ((|bits[43:0]) || bits[45]);
        m    = {2'b01, bits[51:45]} + {8'b0, up};
        if (m[8]) e++;
        if (e >= 255) return {bits[63], 15'h7F80};
        if (e <= 0)   return {bits[63], 15'h0000};
        return {bits[63], e[7:0], m[6:0]};
    endfunction

    function automatic logic [15:0] ref_lane(input logic [15:0] x, input logic [15:0] y, input logic sub);
        real rx, ry;
        rx = bf_to_real(x);
        ry = bf_to_real(y);
        return real_to_bf(sub ? rx - ry : rx + ry);
    endfunction

    function automatic logic [15:0] rnd_norm();
        logic [15:0] h;
        h[15]   = 1'($urandom_range(0, 1));
        h[14:7] = 8'($urandom_range(1, 254));
        h[6:0]  = 7'($urandom_range(0, 127));
        return h;
    endfunction

    task automatic cyc_a(input logic v, input logic [31:0] x, input logic [31:0] y, input logic [1:0] sub,
                         input logic ordy, input logic [31:0] expr, output logic acc);
        a_in_valid = v; a_x = x; a_y = y; a_in_sub = sub; a_out_ready = ordy;
        #1;
        if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) chk("a_spurious_out", 64'(a_out_valid), 64'd0);
            else                chk("a_result", 64'(a_r), 64'(qa.pop_front()));
        end
        acc = v && a_in_ready;
        if (acc) qa.push_back(expr);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] wx [6] = '{32'h7F7F_3F80, 32'h7F80_3F80, 32'h7FC1_3F80, 32'h0001_3F80, 32'h8000_4000, 32'hFF80_C040};
    logic [31:0] wy [6] = '{32'h7F7F_3B80, 32'hFF80_3BC0, 32'h3F80_3F80, 32'h3F80_0001, 32'h8000_3F80, 32'h4000_C040};
    logic [1:0]  ws [6] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b10};
    logic [31:0] wr [6] = '{32'h7F80_3F80, 32'h7FC0_3F81, 32'h7FC0_0000, 32'h3F80_3F80, 32'h8000_3F80, 32'hFF80_C0C0};

    initial begin
        logic        acc;
        int          idx, sent, cyc;
        logic        have, v;
        logic [63:0] cx, cy, cexp;
        logic [3:0]  csub;

        rst_n = 1'b0;
        a_in_valid = 0; a_x = 0; a_y = 0; a_in_sub = 0; a_out_ready = 1;
        b_in_valid = 0; b_x = 0; b_y = 0; b_in_sub = 0; b_out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_a_r", 64'(a_r), 64'd0);
        chk("rst_b_out_valid", 64'(b_out_valid), 64'd0);
        chk("rst_b_r", b_r, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_a_in_ready", 64'(a_in_ready), 64'd1);
        chk("rst_b_in_ready", 64'(b_in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Latency: word presented in cycle 0 is valid at the start of cycle 2.
        cyc_a(1'b1, 32'h3F80_3F80, 32'h3F80_4000, 2'b00, 1'b1, 32'h4000_4040, acc);
        chk("lat_accept", 64'(acc), 64'd1);
        chk("lat_not_yet", 64'(a_out_valid), 64'd0);
        cyc_a(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 32'h0, acc);
        chk("lat_valid", 64'(a_out_valid), 64'd1);
        repeat (4) cyc_a(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 32'h0, acc);
        chk("lat_drained", 64'(qa.size()), 64'd0);

        // Backpressure with the directed rounding/special vectors.
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            if (c >= 2 && c <= 6) begin
                chk("bp_out_valid_hold", 64'(a_out_valid), 64'd1);
                chk("bp_r_hold", 64'(a_r), 64'(wr[0]));
                chk("bp_in_ready_low", 64'(a_in_ready), 64'd0);
            end
            v = (idx < 6);
            cyc_a(v, wx[v ? idx : 0], wy[v ? idx : 0], ws[v ? idx : 0], c >= 7, wr[v ? idx : 0], acc);
            if (acc) idx++;
        end
        chk("bp_all_sent", 64'(idx), 64'd6);
        chk("bp_drained", 64'(qa.size()), 64'd0);

        // Reset mid-stream with two words in flight.
        cyc_a(1'b1, wx[0], wy[0], ws[0], 1'b1, wr[0], acc);
        cyc_a(1'b1, wx[1], wy[1], ws[1], 1'b1, wr[1], acc);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("mid_rst_r", 64'(a_r), 64'd0);
        qa.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk("post_rst_idle", 64'(a_out_valid), 64'd0);
            cyc_a(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 32'h0, acc);
        end
        cyc_a(1'b1, wx[2], wy[2], ws[2], 1'b1, wr[2], acc);
        cyc_a(1'b1, wx[3], wy[3], ws[3], 1'b1, wr[3], acc);
        repeat (5) cyc_a(1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 32'h0, acc);
        chk("post_rst_drained", 64'(qa.size()), 64'd0);

        // Random normal-only vectors on the 4-lane, 3-stage instance.
        sent = 0; cyc = 0; have = 1'b0;
        cx = '0; cy = '0; csub = '0; cexp = '0;
        while ((sent < 4000 || qb.size() > 0) && cyc < 60000) begin
            if (!have && sent < 4000) begin
                for (int l = 0; l < 4; l++) begin
                    cx[16*l +: 16] = rnd_norm();
                    cy[16*l +: 16] = rnd_norm();
                    csub[l]        = 1'($urandom_range(0, 1));
                    cexp[16*l +: 16] = ref_lane(cx[16*l +: 16], cy[16*l +: 16], csub[l]);
                end
                have = 1'b1;
            end
            v = have && ($urandom_range(0, 3) != 0);
            b_in_valid = v; b_x = cx; b_y = cy; b_in_sub = csub;
            b_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (b_out_valid && b_out_ready) begin
                if (qb.size() == 0) chk("b_spurious_out", 64'(b_out_valid), 64'd0);
                else                chk("b_rand", b_r, qb.pop_front());
            end
            if (v && b_in_ready) begin
                qb.push_back(cexp);
                sent++;
                have = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        b_in_valid = 1'b0;
        chk("b_no_timeout", 64'(cyc < 60000), 64'd1);
        chk("b_all_sent", 64'(sent), 64'd4000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
